// File: rtl/mac_array_pkg.sv
// Shared types, widths and saturation-limit helpers for the mac_array MAC engine.
package mac_array_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int PROD_WIDTH     = 2 * DEF_DATA_WIDTH;
  localparam int MAX_ACC_WIDTH  = 64;

  typedef struct packed {
    logic valid;
    logic last;
  } beat_ctl_t;

  // Limits are returned zero-padded to MAX_ACC_WIDTH; callers keep the low acc_width bits.
  function automatic logic [MAX_ACC_WIDTH-1:0] sat_max(int acc_width, logic is_signed);
    logic [MAX_ACC_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_ACC_WIDTH; i++)
      if (i < acc_width - (is_signed ? 1 : 0)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [MAX_ACC_WIDTH-1:0] sat_min(int acc_width, logic is_signed);
    logic [MAX_ACC_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_ACC_WIDTH; i++)
      if (is_signed && i == acc_width - 1) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int lane_lo(int lane, int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mac_array_if.sv
// Operand input stream and result output stream of the mac_array engine.
interface mac_array_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int ACC_WIDTH  = 3 * DATA_WIDTH
);
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_last;
  logic [NUM_LANES*DATA_WIDTH-1:0] a_vec;
  logic [NUM_LANES*DATA_WIDTH-1:0] b_vec;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_LANES*ACC_WIDTH-1:0]  acc_vec;
  logic [NUM_LANES-1:0]            sat_flag;

  modport master (
    output in_valid, in_last, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, acc_vec, sat_flag
  );

  modport slave (
    input  in_valid, in_last, a_vec, b_vec, out_ready,
    output in_ready, out_valid, acc_vec, sat_flag
  );
endinterface

// File: rtl/mac_array_lane.sv
// One MAC lane: operand and product registers, saturating accumulator, sticky flag.
module mac_lane
  import mac_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = PROD_WIDTH + DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  signed_mode,
  input  logic                  acc_valid,
  input  logic                  acc_last,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  res,
  output logic                  res_sat
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int XW = ACC_WIDTH + 1 - PW;
  localparam logic [MAX_ACC_WIDTH-1:0] SMAX_W = sat_max(ACC_WIDTH, 1'b1);
  localparam logic [MAX_ACC_WIDTH-1:0] SMIN_W = sat_min(ACC_WIDTH, 1'b1);
  localparam logic [MAX_ACC_WIDTH-1:0] UMAX_W = sat_max(ACC_WIDTH, 1'b0);
  localparam logic [ACC_WIDTH-1:0] SMAX = SMAX_W[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] SMIN = SMIN_W[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] UMAX = UMAX_W[ACC_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]         a_x, b_x, prod_q, prod_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, clamped;
  logic                  sticky_q, sticky_d, ovf;
  logic [ACC_WIDTH:0]    sum;

  always_comb begin
    a_d = en ? a : a_q;
    b_d = en ? b : b_q;
    // One multiplier serves both modes: low PW bits of the extended product are exact.
    a_x = {{DATA_WIDTH{signed_mode & a_q[DATA_WIDTH-1]}}, a_q};
    b_x = {{DATA_WIDTH{signed_mode & b_q[DATA_WIDTH-1]}}, b_q};
    prod_d = en ? a_x * b_x : prod_q;

    sum = {signed_mode & acc_q[ACC_WIDTH-1], acc_q}
        + {{XW{signed_mode & prod_q[PW-1]}}, prod_q};
    if (signed_mode) begin
      ovf     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      clamped = ovf ? (sum[ACC_WIDTH] ? SMIN : SMAX) : sum[ACC_WIDTH-1:0];
    end else begin
      ovf     = sum[ACC_WIDTH];
      clamped = ovf ? UMAX : sum[ACC_WIDTH-1:0];
    end
    res     = clamped;
    res_sat = sticky_q | ovf;

    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (clr) begin
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (en && acc_valid) begin
      acc_d    = acc_last ? '0 : clamped;
      sticky_d = acc_last ? 1'b0 : res_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end
endmodule

// File: rtl/mac_array.sv
// Multi-lane pipelined MAC engine: valid/last pipeline, stall control and result register.
module mac_array
  import mac_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_LANES  = 4,
  parameter int ACC_WIDTH  = 3 * DATA_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signed_mode,
  input  logic       clr,
  mac_array_if.slave bus
);
  logic                           stall, en, complete;
  beat_ctl_t                      s1_q, s1_d, s2_q, s2_d;
  logic                           out_valid_q, out_valid_d;
  logic [NUM_LANES*ACC_WIDTH-1:0] acc_vec_q, acc_vec_d, lane_res;
  logic [NUM_LANES-1:0]           sat_flag_q, sat_flag_d, lane_sat;

  assign stall    = out_valid_q & ~bus.out_ready;
  assign en       = ~stall;
  assign complete = en & s2_q.valid & s2_q.last & ~clr;

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (clr) begin
      s1_d = '0;
      s2_d = '0;
    end else if (en) begin
      s1_d.valid = bus.in_valid;
      s1_d.last  = bus.in_last;
      s2_d       = s1_q;
    end

    out_valid_d = out_valid_q;
    acc_vec_d   = acc_vec_q;
    sat_flag_d  = sat_flag_q;
    // A completion on the transfer edge keeps out_valid high with the new result.
    if (complete) begin
      out_valid_d = 1'b1;
      acc_vec_d   = lane_res;
      sat_flag_d  = lane_sat;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      acc_vec_q   <= '0;
      sat_flag_q  <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      acc_vec_q   <= acc_vec_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int DLO = lane_lo(i, DATA_WIDTH);
    localparam int ALO = lane_lo(i, ACC_WIDTH);
    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .clr         (clr),
      .signed_mode (signed_mode),
      .acc_valid   (s2_q.valid),
      .acc_last    (s2_q.last),
      .a           (bus.a_vec[DLO +: DATA_WIDTH]),
      .b           (bus.b_vec[DLO +: DATA_WIDTH]),
      .res         (lane_res[ALO +: ACC_WIDTH]),
      .res_sat     (lane_sat[i])
    );
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_vec   = acc_vec_q;
  assign bus.sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_mac_array.sv
// Directed bench for mac_array: latency, signed/unsigned math, saturation, backpressure, clr, reset.
module tb_mac_array;
  localparam int DW = 8;
  localparam int NL = 4;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed_mode = 1'b0;
  logic clr = 1'b0;

  mac_array_if #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(AW)) bus ();

  mac_array #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .signed_mode (signed_mode),
    .clr         (clr),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NL*DW-1:0] rep8(input logic [DW-1:0] v);
    return {NL{v}};
  endfunction

  function automatic logic [NL*AW-1:0] rep24(input logic [AW-1:0] v);
    return {NL{v}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NL*DW-1:0] a, input logic [NL*DW-1:0] b, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a_vec    = a;
    bus.b_vec    = b;
    bus.in_last  = last;
    while (!bus.in_ready && n < 400) begin
      step();
      n++;
    end
    if (!bus.in_ready) check("send_timeout", bus.in_ready, 1'b1);
    else step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    if (!bus.out_valid) check("valid_timeout", bus.out_valid, 1'b1);
  endtask

  task automatic wait_result(output logic [NL*AW-1:0] acc, output logic [NL-1:0] sat);
    wait_valid();
    acc = bus.acc_vec;
    sat = bus.sat_flag;
    step();
  endtask

  logic [NL*AW-1:0] acc;
  logic [NL-1:0]    sat;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.a_vec     = '0;
    bus.b_vec     = '0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_acc", bus.acc_vec, '0);
    check("rst_sat", bus.sat_flag, '0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // unsigned 3 x 10*20 with exact latency
    send(rep8(8'd10), rep8(8'd20), 1'b0);
    send(rep8(8'd10), rep8(8'd20), 1'b0);
    send(rep8(8'd10), rep8(8'd20), 1'b1);
    check("lat_e0", bus.out_valid, 1'b0);
    step();
    check("lat_e1", bus.out_valid, 1'b0);
    step();
    check("lat_e2", bus.out_valid, 1'b1);
    check("u_acc", bus.acc_vec, rep24(24'd600));
    check("u_sat", bus.sat_flag, 4'h0);
    step();
    check("u_drop", bus.out_valid, 1'b0);

    // signed
    signed_mode = 1'b1;
    send({8'h00, 8'h00, 8'h80, 8'hFD}, {8'h00, 8'h00, 8'h80, 8'h05}, 1'b0);
    send({8'h00, 8'h00, 8'h00, 8'hFD}, {8'h00, 8'h00, 8'h00, 8'h05}, 1'b1);
    wait_result(acc, sat);
    check("s_acc", acc, {24'h000000, 24'h000000, 24'h004000, 24'hFFFFE2});
    check("s_sat", sat, 4'h0);
    signed_mode = 1'b0;

    // unsigned saturation then fresh sum
    repeat (258) send(rep8(8'hFF), rep8(8'hFF), 1'b0);
    send(rep8(8'hFF), rep8(8'hFF), 1'b1);
    wait_result(acc, sat);
    check("sat_acc", acc, rep24(24'hFFFFFF));
    check("sat_flag", sat, 4'hF);
    send(rep8(8'd1), rep8(8'd1), 1'b1);
    wait_result(acc, sat);
    check("post_sat_acc", acc, rep24(24'd1));
    check("post_sat_flag", sat, 4'h0);

    // backpressure: result pending while two more products queue behind it
    bus.out_ready = 1'b0;
    fork
      begin
        send(rep8(8'd3), rep8(8'd4), 1'b1);
        send(rep8(8'd2), rep8(8'd5), 1'b1);
        send(rep8(8'd6), rep8(8'd6), 1'b1);
      end
    join_none
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", bus.in_ready, 1'b0);
      check("bp_hold", bus.acc_vec, rep24(24'd12));
      step();
    end
    bus.out_ready = 1'b1;
    wait_result(acc, sat);
    check("bp_res0", acc, rep24(24'd12));
    wait_result(acc, sat);
    check("bp_res1", acc, rep24(24'd10));
    wait_result(acc, sat);
    check("bp_res2", acc, rep24(24'd36));
    check("bp_empty", bus.out_valid, 1'b0);

    // clr while stalled: pending result survives, queued beats are flushed
    bus.out_ready = 1'b0;
    fork
      begin
        send(rep8(8'd9), rep8(8'd9), 1'b1);
        send(rep8(8'd5), rep8(8'd5), 1'b0);
        send(rep8(8'd5), rep8(8'd5), 1'b0);
      end
    join_none
    wait_valid();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_pending_valid", bus.out_valid, 1'b1);
    check("clr_pending_acc", bus.acc_vec, rep24(24'd81));
    bus.out_ready = 1'b1;
    wait_result(acc, sat);
    check("clr_pending_res", acc, rep24(24'd81));
    send(rep8(8'd2), rep8(8'd3), 1'b1);
    wait_result(acc, sat);
    check("clr_stall_res", acc, rep24(24'd6));

    // clr after accumulation, with a beat presented on the clr cycle
    send(rep8(8'd5), rep8(8'd5), 1'b0);
    send(rep8(8'd5), rep8(8'd5), 1'b0);
    repeat (3) step();
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a_vec    = rep8(8'd7);
    bus.b_vec    = rep8(8'd7);
    bus.in_last  = 1'b1;
    step();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) step();
    check("clr_discard", bus.out_valid, 1'b0);
    send(rep8(8'd2), rep8(8'd3), 1'b1);
    wait_result(acc, sat);
    check("clr_acc", acc, rep24(24'd6));
    check("clr_sat", sat, 4'h0);

    // async reset with a result pending and beats in flight
    bus.out_ready = 1'b0;
    fork
      begin
        send(rep8(8'd1), rep8(8'd1), 1'b1);
        send(rep8(8'd4), rep8(8'd4), 1'b0);
        send(rep8(8'd4), rep8(8'd4), 1'b1);
      end
    join_none
    wait_valid();
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_acc", bus.acc_vec, '0);
    check("arst_sat", bus.sat_flag, '0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) step();
    check("arst_clean", bus.out_valid, 1'b0);
    send(rep8(8'd3), rep8(8'd7), 1'b1);
    wait_result(acc, sat);
    check("arst_acc_after", acc, rep24(24'd21));
    check("arst_sat_after", sat, 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
